// File: rtl/ttt_pkg.sv
// Shared codes and FSM states for the tic-tac-toe grid.
// Imported by the grid top and the win detector.
package ttt_pkg;

  // Cell contents
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] PLYR  = 2'b01;
  localparam logic [1:0] COMP  = 2'b10;

  // Game result
  localparam logic [1:0] RUN   = 2'b00;
  localparam logic [1:0] P_WIN = 2'b01;
  localparam logic [1:0] C_WIN = 2'b10;
  localparam logic [1:0] DRAW  = 2'b11;

  typedef enum logic [1:0] {
    P_TURN,
    C_TURN,
    CHECK,
    OVER
  } state_e;

  // Result code for a winning mark
  function automatic logic [1:0] win_code(
    input logic [1:0] mark
  );
    return (mark == COMP) ? C_WIN : P_WIN;
  endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational N-in-a-row detector for one mark.
// Ports: i_board (2 bits per cell), i_mark, o_win.
module ttt_win_detect
  import ttt_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2*N*N-1:0] i_board,
  input  logic [1:0]       i_mark,
  output logic             o_win
);

  logic [N-1:0] w_row;
  logic [N-1:0] w_col;
  logic         w_dia;
  logic         w_anti;

  // Each line starts as a candidate and
  // is knocked out by any mismatching cell.
  always_comb begin
    w_row  = '1;
    w_col  = '1;
    w_dia  = 1'b1;
    w_anti = 1'b1;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (i_board[2*(r*N+c) +: 2] != i_mark) begin
          w_row[r] = 1'b0;
          w_col[c] = 1'b0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (i_board[2*(i*N+i) +: 2] != i_mark)
        w_dia = 1'b0;
      if (i_board[2*(i*N+N-1-i) +: 2] != i_mark)
        w_anti = 1'b0;
    end
  end

  // An empty mark never wins.
  assign o_win = (i_mark != EMPTY) &&
                 ((|w_row) || (|w_col) ||
                  w_dia || w_anti);

endmodule

// File: rtl/tic_tac_toe_grid.sv
// Two-party N x N tic-tac-toe referee: board, turn, result.
// Ports: clk, reset(n), new_game, play/pc strobes, positions; board, who, turn, illegal, move_cnt.
module tic_tac_toe_grid
  import ttt_pkg::*;
#(
  parameter  int N     = 3,
  localparam int CELLS = N*N,
  localparam int POS_W = $clog2(CELLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic               play,
  input  logic               pc,
  input  logic [POS_W-1:0]   plyr_pos,
  input  logic [POS_W-1:0]   comp_pos,
  output logic [2*CELLS-1:0] board,
  output logic [1:0]         who,
  output logic               turn,
  output logic               illegal,
  output logic [POS_W:0]     move_cnt
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [2*CELLS-1:0]   r_board;
  logic [1:0]           r_who;
  logic                 r_turn;
  logic                 r_illegal;
  logic [POS_W:0]       r_move_cnt;

  logic [POS_W-1:0]     w_pos;
  logic [1:0]           w_cell;
  logic                 w_in_rng;
  logic [1:0]           w_mark;
  logic                 w_stb;
  logic                 w_chk;
  logic                 w_acc;
  logic                 w_rej;
  logic                 w_win;
  logic                 w_full;

  // The mover's mark follows turn; turn only
  // flips after CHECK, so it still names the
  // last mover while CHECK evaluates.
  assign w_mark = r_turn ? COMP : PLYR;
  assign w_full = (r_move_cnt == (POS_W+1)'(CELLS));

  ttt_win_detect #(
    .N (N)
  ) u_win (
    .i_board (r_board),
    .i_mark  (w_mark),
    .o_win   (w_win)
  );

  // Target cell lookup for the on-turn side
  always_comb begin
    w_pos    = (r_state == C_TURN) ?
               comp_pos : plyr_pos;
    w_cell   = EMPTY;
    w_in_rng = (int'(w_pos) < CELLS);
    for (int i = 0; i < CELLS; i++) begin
      if (w_pos == POS_W'(i))
        w_cell = r_board[2*i +: 2];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= P_TURN;
    else
      r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      P_TURN,
      C_TURN: begin
        if (w_acc)
          w_state_nxt = CHECK;
      end
      CHECK: begin
        if (w_win || w_full)
          w_state_nxt = OVER;
        else if (r_turn)
          w_state_nxt = P_TURN;
        else
          w_state_nxt = C_TURN;
      end
      OVER: w_state_nxt = OVER;
      default: w_state_nxt = P_TURN;
    endcase
    if (new_game)
      w_state_nxt = P_TURN;
  end

  // FSM outputs: only the on-turn strobe
  // is looked at; CHECK and OVER drop both.
  always_comb begin
    w_stb = 1'b0;
    w_chk = 1'b0;
    unique case (r_state)
      P_TURN:  w_stb = play;
      C_TURN:  w_stb = pc;
      CHECK:   w_chk = 1'b1;
      OVER:    w_stb = 1'b0;
      default: w_stb = 1'b0;
    endcase
    w_acc = w_stb && w_in_rng &&
            (w_cell == EMPTY);
    w_rej = w_stb && !w_acc;
  end

  // Game datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_board    <= '0;
      r_who      <= RUN;
      r_turn     <= 1'b0;
      r_illegal  <= 1'b0;
      r_move_cnt <= '0;
    end else if (new_game) begin
      r_board    <= '0;
      r_who      <= RUN;
      r_turn     <= 1'b0;
      r_illegal  <= 1'b0;
      r_move_cnt <= '0;
    end else begin
      r_illegal <= w_rej;
      if (w_acc) begin
        for (int i = 0; i < CELLS; i++) begin
          if (w_pos == POS_W'(i))
            r_board[2*i +: 2] <= w_mark;
        end
        r_move_cnt <= r_move_cnt + 1'b1;
      end
      if (w_chk) begin
        if (w_win)
          r_who <= win_code(w_mark);
        else if (w_full)
          r_who <= DRAW;
        else
          r_turn <= !r_turn;
      end
    end
  end

  assign board    = r_board;
  assign who      = r_who;
  assign turn     = r_turn;
  assign illegal  = r_illegal;
  assign move_cnt = r_move_cnt;

endmodule

// File: tb/tb_tic_tac_toe_grid.sv
// Self-checking bench for tic_tac_toe_grid (N=3 and N=4).
// Table vectors, hand corner sequences, random games vs a model.
module tb_tic_tac_toe_grid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        new_game, play, pc;
  logic [3:0]  plyr_pos, comp_pos;
  logic [17:0] board;
  logic [1:0]  who;
  logic        turn, illegal;
  logic [4:0]  move_cnt;

  logic        ng4, play4, pc4;
  logic [3:0]  pp4, cp4;
  logic [31:0] board4;
  logic [1:0]  who4;
  logic        turn4, ill4;
  logic [4:0]  cnt4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tic_tac_toe_grid #(.N(3)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .new_game (new_game),
    .play     (play),
    .pc       (pc),
    .plyr_pos (plyr_pos),
    .comp_pos (comp_pos),
    .board    (board),
    .who      (who),
    .turn     (turn),
    .illegal  (illegal),
    .move_cnt (move_cnt)
  );

  tic_tac_toe_grid #(.N(4)) dut4 (
    .clk      (clk),
    .reset    (rst_n),
    .new_game (ng4),
    .play     (play4),
    .pc       (pc4),
    .plyr_pos (pp4),
    .comp_pos (cp4),
    .board    (board4),
    .who      (who4),
    .turn     (turn4),
    .illegal  (ill4),
    .move_cnt (cnt4)
  );

  function automatic void chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  // One move attempt: strobe for one edge, then
  // one idle edge so CHECK has resolved.
  task automatic step3(
    input bit ng, input bit p, input bit c,
    input int pp, input int cp,
    output bit ill1, output bit ill2
  );
    @(negedge clk);
    new_game = ng; play = p; pc = c;
    plyr_pos = 4'(pp); comp_pos = 4'(cp);
    @(posedge clk); #1;
    ill1 = illegal;
    @(negedge clk);
    new_game = 0; play = 0; pc = 0;
    @(posedge clk); #1;
    ill2 = illegal;
  endtask

  task automatic step4(
    input bit ng, input bit p, input bit c,
    input int pos
  );
    @(negedge clk);
    ng4 = ng; play4 = p; pc4 = c;
    pp4 = 4'(pos); cp4 = 4'(pos);
    @(posedge clk); #1;
    @(negedge clk);
    ng4 = 0; play4 = 0; pc4 = 0;
    @(posedge clk); #1;
  endtask

  // Reference model: game rules on an array
  int m_b[9];
  int m_turn, m_who, m_cnt;
  bit m_over;

  function automatic void m_clear();
    foreach (m_b[i]) m_b[i] = 0;
    m_turn = 0; m_who = 0; m_cnt = 0;
    m_over = 0;
  endfunction

  function automatic bit m_won(input int mk);
    int rc[3], cc[3], d, a, r, c;
    rc = '{0, 0, 0}; cc = '{0, 0, 0};
    d = 0; a = 0;
    for (int i = 0; i < 9; i++) begin
      if (m_b[i] == mk) begin
        r = i / 3; c = i % 3;
        rc[r]++; cc[c]++;
        if (r == c) d++;
        if (r + c == 2) a++;
      end
    end
    m_won = (d == 3) || (a == 3);
    for (int k = 0; k < 3; k++)
      if (rc[k] == 3 || cc[k] == 3) m_won = 1;
  endfunction

  function automatic bit m_step(
    input bit p, input bit c,
    input int pp, input int cp
  );
    int pos, mk;
    m_step = 0;
    if (m_over) return 0;
    if (!(m_turn == 0 ? p : c)) return 0;
    pos = m_turn ? cp : pp;
    if (pos >= 9 || m_b[pos] != 0) return 1;
    mk = m_turn + 1;
    m_b[pos] = mk;
    m_cnt++;
    if (m_won(mk)) begin
      m_who = mk; m_over = 1;
    end else if (m_cnt == 9) begin
      m_who = 3; m_over = 1;
    end else begin
      m_turn = 1 - m_turn;
    end
  endfunction

  function automatic logic [17:0] m_board();
    m_board = '0;
    for (int i = 0; i < 9; i++)
      m_board[2*i +: 2] = 2'(m_b[i]);
  endfunction

  typedef struct {
    bit ng; bit p; bit c;
    int pp; int cp;
    bit e_ill; int e_cnt;
    int e_who; bit e_turn;
  } vec_t;

  vec_t vt[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    bit i1, i2, e_ill;
    int s4[8];
    int pp, cp, r;
    bit p, c;

    // game A: player wins top row
    vt.push_back('{1,0,0,0,0, 0,0,0,0});
    vt.push_back('{0,1,0,0,0, 0,1,0,1});
    vt.push_back('{0,0,1,0,4, 0,2,0,0});
    vt.push_back('{0,1,0,1,0, 0,3,0,1});
    vt.push_back('{0,0,1,0,8, 0,4,0,0});
    vt.push_back('{0,1,0,2,0, 0,5,1,0});
    vt.push_back('{0,1,0,3,0, 0,5,1,0});
    vt.push_back('{0,0,1,0,3, 0,5,1,0});
    // game B: off-turn, occupied, range, both
    vt.push_back('{1,0,0,0,0, 0,0,0,0});
    vt.push_back('{0,1,0,0,0, 0,1,0,1});
    vt.push_back('{0,1,0,4,0, 0,1,0,1});
    vt.push_back('{0,0,1,0,0, 1,1,0,1});
    vt.push_back('{0,0,1,0,9, 1,1,0,1});
    vt.push_back('{0,1,1,7,4, 0,2,0,0});
    vt.push_back('{0,1,1,4,6, 1,2,0,0});
    vt.push_back('{0,1,0,15,0, 1,2,0,0});
    vt.push_back('{0,1,0,0,0, 1,2,0,0});
    // out of range on an empty board
    vt.push_back('{1,0,0,0,0, 0,0,0,0});
    vt.push_back('{0,1,0,9,0, 1,0,0,0});
    // game C: full-board draw
    vt.push_back('{1,0,0,0,0, 0,0,0,0});
    vt.push_back('{0,1,0,0,0, 0,1,0,1});
    vt.push_back('{0,0,1,0,1, 0,2,0,0});
    vt.push_back('{0,1,0,2,0, 0,3,0,1});
    vt.push_back('{0,0,1,0,4, 0,4,0,0});
    vt.push_back('{0,1,0,3,0, 0,5,0,1});
    vt.push_back('{0,0,1,0,5, 0,6,0,0});
    vt.push_back('{0,1,0,7,0, 0,7,0,1});
    vt.push_back('{0,0,1,0,6, 0,8,0,0});
    vt.push_back('{0,1,0,8,0, 0,9,3,0});
    vt.push_back('{0,1,0,0,0, 0,9,3,0});

    rst_n = 0; new_game = 0; play = 0; pc = 0;
    plyr_pos = 0; comp_pos = 0;
    ng4 = 0; play4 = 0; pc4 = 0; pp4 = 0; cp4 = 0;

    #3;
    chk("rst board", board, 0);
    chk("rst who", who, 0);
    chk("rst turn", turn, 0);
    chk("rst illegal", illegal, 0);
    chk("rst cnt", move_cnt, 0);
    chk("rst board4", board4, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    foreach (vt[i]) begin
      step3(vt[i].ng, vt[i].p, vt[i].c,
            vt[i].pp, vt[i].cp, i1, i2);
      chk($sformatf("vec%0d ill", i), i1, vt[i].e_ill);
      chk($sformatf("vec%0d ill_end", i), i2, 0);
      chk($sformatf("vec%0d cnt", i), move_cnt, vt[i].e_cnt);
      chk($sformatf("vec%0d who", i), who, vt[i].e_who);
      chk($sformatf("vec%0d turn", i), turn, vt[i].e_turn);
      if (vt[i].e_cnt == 0)
        chk($sformatf("vec%0d board0", i), board, 0);
    end

    // latency: mark after 1 edge, result after 2
    step3(1, 0, 0, 0, 0, i1, i2);
    step3(0, 1, 0, 0, 0, i1, i2);
    step3(0, 0, 1, 0, 3, i1, i2);
    step3(0, 1, 0, 1, 0, i1, i2);
    step3(0, 0, 1, 0, 4, i1, i2);
    @(negedge clk); play = 1; plyr_pos = 2;
    @(posedge clk); #1;
    chk("lat cell2", board[5:4], 2'b01);
    chk("lat who early", who, 0);
    @(negedge clk); play = 0;
    @(posedge clk); #1;
    chk("lat who", who, 2'b01);

    // held strobes, strobe during CHECK
    step3(1, 0, 0, 0, 0, i1, i2);
    @(negedge clk); play = 1; plyr_pos = 0;
    @(posedge clk); #1;
    chk("hold acc cnt", move_cnt, 1);
    @(posedge clk); #1;
    chk("hold chk ill", illegal, 0);
    chk("hold chk turn", turn, 1);
    @(posedge clk); #1;
    chk("hold cturn ill", illegal, 0);
    chk("hold cturn cnt", move_cnt, 1);
    @(negedge clk); play = 0; pc = 1; comp_pos = 0;
    @(posedge clk); #1;
    chk("retry ill1", illegal, 1);
    @(posedge clk); #1;
    chk("retry ill2", illegal, 1);
    @(negedge clk); pc = 0;
    @(posedge clk); #1;
    chk("retry ill off", illegal, 0);
    chk("retry turn", turn, 1);

    // new_game beats a same-cycle move
    @(negedge clk); new_game = 1; pc = 1; comp_pos = 5;
    @(posedge clk); #1;
    chk("ngov board", board, 0);
    chk("ngov cnt", move_cnt, 0);
    chk("ngov turn", turn, 0);
    @(negedge clk); new_game = 0; pc = 0;

    // asynchronous reset mid-game
    step3(0, 1, 0, 0, 0, i1, i2);
    step3(0, 0, 1, 0, 1, i1, i2);
    step3(0, 1, 0, 2, 0, i1, i2);
    step3(0, 0, 1, 0, 3, i1, i2);
    chk("pre rst cnt", move_cnt, 4);
    @(negedge clk); #2;
    rst_n = 0; #1;
    chk("arst board", board, 0);
    chk("arst turn", turn, 0);
    chk("arst cnt", move_cnt, 0);
    chk("arst who", who, 0);
    @(negedge clk); rst_n = 1;
    step3(0, 1, 0, 4, 0, i1, i2);
    chk("post rst board", board, 18'h100);
    chk("post rst cnt", move_cnt, 1);

    // N=4: computer takes the anti-diagonal
    s4 = '{0, 3, 1, 6, 2, 9, 4, 12};
    step4(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step4(0, (k % 2) == 0, (k % 2) == 1, s4[k]);
      chk($sformatf("n4 cnt%0d", k), cnt4, k + 1);
      chk($sformatf("n4 who%0d", k), who4,
          (k == 7) ? 2 : 0);
    end
    chk("n4 turn", turn4, 1);
    chk("n4 cell12", board4[25:24], 2'b10);

    // random games against the model
    for (int g = 0; g < 40; g++) begin
      step3(1, 0, 0, 0, 0, i1, i2);
      m_clear();
      chk("rnd ng board", board, 0);
      for (int s = 0; s < 25; s++) begin
        r = $urandom_range(0, 19);
        if (r < 14) begin
          p = (m_turn == 0); c = (m_turn == 1);
        end else if (r < 17) begin
          p = (m_turn == 1); c = (m_turn == 0);
        end else if (r < 19) begin
          p = 1; c = 1;
        end else begin
          p = 0; c = 0;
        end
        pp = ($urandom_range(0, 7) == 0) ?
             $urandom_range(9, 15) : $urandom_range(0, 8);
        cp = ($urandom_range(0, 7) == 0) ?
             $urandom_range(9, 15) : $urandom_range(0, 8);
        e_ill = m_step(p, c, pp, cp);
        step3(0, p, c, pp, cp, i1, i2);
        chk($sformatf("rnd g%0d s%0d ill", g, s), i1, e_ill);
        chk($sformatf("rnd g%0d s%0d ill_end", g, s), i2, 0);
        chk($sformatf("rnd g%0d s%0d board", g, s),
            board, m_board());
        chk($sformatf("rnd g%0d s%0d who", g, s), who, m_who);
        chk($sformatf("rnd g%0d s%0d turn", g, s), turn, m_turn);
        chk($sformatf("rnd g%0d s%0d cnt", g, s),
            move_cnt, m_cnt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
